// File: rtl/tx_iq_feeder.sv
//------------------------------------------------------------------------------
// tx_iq_feeder: X/Y pair FIFO answering CIC interpolator sample requests.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tx_iq_feeder #(
  parameter int DEPTH_LOG2 = 5,
  parameter int PRIME      = 16
) (
  input  logic                  dclk,
  input  logic                  rstn,
  input  logic [17:0]           wdx,
  input  logic [17:0]           wdy,
  input  logic                  wr,
  input  logic                  flush,
  input  logic                  run,
  input  logic                  tie,
  input  logic                  unf_clr,
  output logic [17:0]           tdix,
  output logic [17:0]           tdiy,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  active,
  output logic                  unf,
  output logic                  wovf
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_PRIME = (DEPTH_LOG2 + 1)'(PRIME);
  localparam logic [DEPTH_LOG2:0] LVL_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [35:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  tie_q;
  logic                  tie_edge;
  logic                  serve;
  logic                  do_wr;
  logic                  do_ovf;
  logic                  do_pop;
  logic                  do_unf;
  logic                  clr_out;

  assign tie_edge = tie & ~tie_q;

  always_ff @(posedge dclk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = run ? S_PRIME : S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (run) state_next = S_PRIME;
        S_PRIME: begin
          if (!run)                    state_next = S_IDLE;
          else if (level >= LVL_PRIME) state_next = S_RUN;
        end
        S_RUN: begin
          if (!run)                          state_next = S_IDLE;
          else if (tie_edge && level == '0)  state_next = S_PRIME;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // A falling run takes priority over a coincident request.
  always_comb begin
    serve      = (state == S_RUN) & run & ~flush & tie_edge;
    do_wr      = wr & ~full & ~flush;
    do_ovf     = wr & full & ~flush;
    do_pop     = serve & (level != '0);
    do_unf     = serve & (level == '0);
    clr_out    = (state_next != S_RUN);
    level_next = level;
    case ({do_wr, do_pop})
      2'b10:   level_next = level + LVL_ONE;
      2'b01:   level_next = level - LVL_ONE;
      default: level_next = level;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (rstn && do_wr) mem[wptr] <= {wdx, wdy};
  end

  always_ff @(posedge dclk) begin
    if (!rstn) begin
      tie_q  <= 1'b0;
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      full   <= 1'b0;
      active <= 1'b0;
      tdix   <= '0;
      tdiy   <= '0;
      unf    <= 1'b0;
      wovf   <= 1'b0;
    end else begin
      tie_q  <= tie;
      active <= (state_next == S_RUN);
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
        full  <= 1'b0;
      end else begin
        if (do_wr)  wptr <= wptr + PTR_ONE;
        if (do_pop) rptr <= rptr + PTR_ONE;
        level <= level_next;
        full  <= (level_next == LVL_DEPTH);
      end
      if (do_pop)       {tdix, tdiy} <= mem[rptr];
      else if (clr_out) {tdix, tdiy} <= '0;
      if (do_unf)       unf <= 1'b1;
      else if (unf_clr) unf <= 1'b0;
      if (do_ovf)       wovf <= 1'b1;
      else if (unf_clr) wovf <= 1'b0;
    end
  end

endmodule

`default_nettype wire
